// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the segment scan controller: BCD width, FSM states,
// and the decoder reset level that blanks the segments.
package seg_scan_ctrl_pkg;

    localparam int   BCD_W     = 4;
    localparam logic DEC_BLANK = 1'b1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Loadable down-counter; terminal count is high while the count sits at zero.
// The scan FSM reuses one instance for both the BLANK and SHOW slot lengths.
module seg_slot_timer
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller driving one shared BCD decoder.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading-zero digits (digit 0 always lit).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_BLANK | gap before a digit slot: digit_en=0, dec_rst=1, dec_num preset
//   ST_SHOW  | digit idx lit for PRESCALE cycles, dec_num held stable
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BCD_W*DIGITS-1:0] bcd_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic [BCD_W-1:0]        dec_num,
    output logic                    dec_rst,
    output logic [DIGITS-1:0]       digit_en,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(max_int(PRESCALE, BLANK_CYCLES) + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    // The post-reset BLANK cycle itself counts as the first blank cycle.
    localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'((BLANK_CYCLES > 1) ? BLANK_CYCLES - 2 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);

    state_t                         state, state_nx;
    logic [IDX_W-1:0]               idx, idx_nx;
    logic                           primed;
    logic [DIGITS-1:0][BCD_W-1:0]   shadow, shadow_nx;
    logic [BCD_W*DIGITS-1:0]        pending;
    logic                           pending_v;
    logic                           tm_load, tm_tc;
    logic [CNT_W-1:0]               tm_val;
    logic                           boundary, apply, dark, shown_nx;

    seg_slot_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tm_load),
        .load_val (tm_val),
        .tc       (tm_tc)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        tm_load  = 1'b0;
        tm_val   = '0;
        boundary = 1'b0;
        case (state)
            ST_BLANK: begin
                if (!primed && (BLANK_CYCLES > 1)) begin
                    tm_load = 1'b1;
                    tm_val  = FIRST_LOAD;
                end else if (!primed || tm_tc) begin
                    state_nx = ST_SHOW;
                    tm_load  = 1'b1;
                    tm_val   = SHOW_LOAD;
                end
            end
            ST_SHOW: begin
                if (tm_tc) begin
                    tm_load  = 1'b1;
                    boundary = (idx == LAST_IDX);
                    idx_nx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    if (BLANK_CYCLES > 0) begin
                        state_nx = ST_BLANK;
                        tm_val   = BLANK_LOAD;
                    end else begin
                        tm_val   = SHOW_LOAD;
                    end
                end
            end
        endcase
    end

    // The shadow only changes on the wrap edge, so every frame shows one word.
    assign apply = boundary && (pending_v || load);

    always_comb begin
        shadow_nx = shadow;
        if (apply) begin
            shadow_nx = load ? bcd_in : pending;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if ((k >= int'(idx_nx)) && (shadow_nx[k] != '0)) begin
                upper_zero = 1'b0;
            end
        end
        dark = (idx_nx != '0) && upper_zero;
    end
`else
    assign dark = 1'b0;
`endif

    assign shown_nx = (state_nx == ST_SHOW) && !dark;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_BLANK;
            idx       <= '0;
            primed    <= 1'b0;
            shadow    <= '0;
            pending   <= '0;
            pending_v <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            primed <= 1'b1;
            shadow <= shadow_nx;
            if (load) begin
                pending <= bcd_in;
            end
            if (apply) begin
                pending_v <= 1'b0;
            end else if (load) begin
                pending_v <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_num    <= '0;
            dec_rst    <= DEC_BLANK;
            digit_en   <= '0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            if ((state == ST_SHOW) && tm_tc) begin
                dec_num <= shadow_nx[idx_nx];
            end
            dec_rst    <= shown_nx ? ~DEC_BLANK : DEC_BLANK;
            digit_en   <= shown_nx ? (DIGITS'(1) << idx_nx) : '0;
            load_ack   <= apply;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a per-cycle reference built from frame/slot
// arithmetic and a log of loads; a negedge monitor pops and compares each cycle.
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int BLANK    = 2;
    localparam int SLOT     = BLANK + PRESCALE;
    localparam int FRAME    = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load_ack, dec_rst, frame_tick;
    logic [3:0]  dec_num;
    logic [3:0]  digit_en;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .load_ack   (load_ack),
        .dec_num    (dec_num),
        .dec_rst    (dec_rst),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] num;
        logic       rs;
        logic [3:0] en;
        logic       ack;
        logic       tick;
    } obs_t;

    obs_t        exp_q[$];
    int          tag_q[$];
    int          cyc_q[$];
    logic [15:0] val_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          t = 0;
    bit          done = 1'b0;

    function automatic logic [15:0] word_for(input int f);
        logic [15:0] w = '0;
        foreach (cyc_q[i]) if (cyc_q[i] < FRAME * f) w = val_q[i];
        return w;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o.num = '0; o.rs = 1'b1; o.en = '0; o.ack = 1'b0; o.tick = 1'b0;
        return o;
    endfunction

    function automatic obs_t model(input int tt);
        obs_t        o;
        int          f = tt / FRAME;
        int          p = tt % FRAME;
        int          s = p / SLOT;
        bit          show = (p % SLOT) >= BLANK;
        logic [15:0] w = word_for(f);
        logic [15:0] upper = w >> (4 * s);
        bit          lit = show;
        bit          any_ld = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (s != 0 && upper == 16'h0) lit = 1'b0;
`endif
        foreach (cyc_q[i]) if (cyc_q[i] >= FRAME * (f - 1) && cyc_q[i] < FRAME * f) any_ld = 1'b1;
        o.num  = upper[3:0];
        o.rs   = !lit;
        o.en   = lit ? 4'(1 << s) : 4'b0;
        o.tick = (tt > 0) && (p == 0);
        o.ack  = o.tick && any_ld;
        return o;
    endfunction

    task automatic cycle(input bit ld, input logic [15:0] v);
        @(posedge clk); #1;
        load   = ld;
        bcd_in = ld ? v : 16'($urandom);
        if (rst) begin
            exp_q.push_back(reset_obs());
            tag_q.push_back(-1);
        end else begin
            if (ld) begin
                cyc_q.push_back(t);
                val_q.push_back(v);
            end
            exp_q.push_back(model(t));
            tag_q.push_back(t);
            t++;
        end
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        rst  = 1'b0;
        load = 1'b0;
        t    = 0;
        cyc_q.delete();
        val_q.delete();
        exp_q.push_back(model(0));
        tag_q.push_back(0);
        t = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0);
    endtask

    task automatic wait_phase(input int p);
        while ((t % FRAME) != p) cycle(1'b0, '0);
    endtask

    task automatic rand_cycles(input int n);
        repeat (n) cycle($urandom_range(0, 11) == 0, 16'($urandom));
    endtask

    task automatic reset_mid_show();
        obs_t act, want;
        wait_phase(15);
        @(posedge clk); #1;
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        act  = {dec_num, dec_rst, digit_en, load_ack, frame_tick};
        want = reset_obs();
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL async_reset: got num=%h rst=%b en=%b, want num=%h rst=%b en=%b",
                     act.num, act.rs, act.en, want.num, want.rs, want.en);
        end
        exp_q.push_back(want);
        tag_q.push_back(-1);
        cyc_q.delete();
        val_q.delete();
        cycle(1'b0, '0);
        release_rst();
    endtask

    always @(negedge clk) begin
        obs_t act, e;
        int   tg;
        if (!done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty: got nothing, want an expectation");
            end else begin
                e   = exp_q.pop_front();
                tg  = tag_q.pop_front();
                act = {dec_num, dec_rst, digit_en, load_ack, frame_tick};
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL cyc%0d: got num=%h rst=%b en=%b ack=%b tick=%b, want num=%h rst=%b en=%b ack=%b tick=%b",
                             tg, act.num, act.rs, act.en, act.ack, act.tick,
                             e.num, e.rs, e.en, e.ack, e.tick);
                end
            end
        end
    end

    initial begin
        repeat (3) cycle(1'b0, '0);
        release_rst();
        idle(5);
        cycle(1'b1, 16'h1234);
        idle(2 * FRAME);
        wait_phase(3);
        cycle(1'b1, 16'h0042);
        idle(6);
        cycle(1'b1, 16'h0099);
        idle(2 * FRAME);
        wait_phase(FRAME - 1);
        cycle(1'b1, 16'h5678);
        idle(FRAME + 4);
        cycle(1'b1, 16'h0007);
        idle(2 * FRAME);
        cycle(1'b1, 16'h0000);
        idle(2 * FRAME);
        cycle(1'b1, 16'hFA0C);
        idle(FRAME);
        rand_cycles(10 * FRAME);
        reset_mid_show();
        idle(3);
        cycle(1'b1, 16'h0305);
        rand_cycles(4 * FRAME);
        @(negedge clk); #1;
        done = 1'b1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
